// File: rtl/fft_pkg.sv
// Shared FFT definitions: radix encoding, lane-to-bank map tables and per-radix
// write-enable masks, used by both the read-side mux and the write-back demux.
package fft_pkg;

    localparam int NUM_LANES = 12;
    localparam int NUM_BANKS = 8;

    typedef enum logic [2:0] {
        P2 = 3'd2,
        P3 = 3'd3,
        P4 = 3'd4,
        P5 = 3'd5,
        P7 = 3'd7
    } fft_point_e;

    // Entry b is the lane index feeding bank b, packed as {b7, b6, ..., b0}.
    // Unused banks point at lane 0; their write enable is masked off.
    typedef logic [NUM_BANKS-1:0][3:0] bank_map_t;

    localparam bank_map_t MAP_P7 = {4'd0, 4'd2, 4'd6, 4'd3, 4'd4, 4'd5, 4'd1, 4'd0};
    localparam bank_map_t MAP_P5 = {4'd0, 4'd0, 4'd0, 4'd2, 4'd3, 4'd4, 4'd1, 4'd0};
    localparam bank_map_t MAP_P4 = {4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 4'd2, 4'd5, 4'd1};
    localparam bank_map_t MAP_P3 = {4'd0, 4'd0, 4'd6, 4'd5, 4'd7, 4'd2, 4'd1, 4'd0};
    localparam bank_map_t MAP_P2 = {4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd2, 4'd1};

    localparam logic [NUM_BANKS-1:0] WR_EN_P7   = 8'h7F;
    localparam logic [NUM_BANKS-1:0] WR_EN_P5   = 8'h1F;
    localparam logic [NUM_BANKS-1:0] WR_EN_P4   = 8'h0F;
    localparam logic [NUM_BANKS-1:0] WR_EN_P3   = 8'h3F;
    localparam logic [NUM_BANKS-1:0] WR_EN_P2M1 = 8'hFF;
    localparam logic [NUM_BANKS-1:0] WR_EN_P2M0 = 8'h3F;

    function automatic logic point_legal(input logic [2:0] point);
        case (point)
            P2, P3, P4, P5, P7: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fft_out_map.sv
// Combinational lane-to-bank reindex for the write-back path, plus the bank
// write-enable mask for the selected radix (all zero for an illegal radix).
module fft_out_map
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [2:0]                           point,
    input  logic                                 point_2_mode,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lanes,
    output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] banks,
    output logic [NUM_BANKS-1:0]                 wr_en
);

    bank_map_t map;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        map   = '0;
        wr_en = '0;
        case (point)
            P7: begin map = MAP_P7; wr_en = WR_EN_P7; end
            P5: begin map = MAP_P5; wr_en = WR_EN_P5; end
            P4: begin map = MAP_P4; wr_en = WR_EN_P4; end
            P3: begin map = MAP_P3; wr_en = WR_EN_P3; end
            P2: begin
                map   = MAP_P2;
                wr_en = point_2_mode ? WR_EN_P2M1 : WR_EN_P2M0;
            end
            default: ;
        endcase
        for (int b = 0; b < NUM_BANKS; b++) begin
            banks[b] = lanes[map[b]];
        end
    end

endmodule

// File: rtl/fft_out_demux.sv
// FFT write-back demux: reindexes the 12 PE output lanes onto the 8 bank write
// ports through a 1-entry output register, sequencing one frame per start pulse.
module fft_out_demux
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            point,
    input  logic                  point_2_mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_0,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_1,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_2,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_3,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_4,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_5,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_6,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_7,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_8,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_9,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_10,
    input  logic [DATA_WIDTH-1:0] FFT_OUT_11,
    input  logic                  mem_ready,
    output logic [NUM_BANKS-1:0]  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_IN_0,
    output logic [DATA_WIDTH-1:0] mem_IN_1,
    output logic [DATA_WIDTH-1:0] mem_IN_2,
    output logic [DATA_WIDTH-1:0] mem_IN_3,
    output logic [DATA_WIDTH-1:0] mem_IN_4,
    output logic [DATA_WIDTH-1:0] mem_IN_5,
    output logic [DATA_WIDTH-1:0] mem_IN_6,
    output logic [DATA_WIDTH-1:0] mem_IN_7,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e                              state_q, state_d;
    logic [2:0]                          cfg_point;
    logic                                cfg_mode;
    logic [LEN_WIDTH-1:0]                cfg_last;
    logic [LEN_WIDTH-1:0]                beat_cnt;
    logic [ADDR_WIDTH-1:0]               addr_ptr;
    logic                                out_vld;
    logic [NUM_BANKS-1:0]                wr_en_q;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] data_q;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lanes;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] map_banks;
    logic [NUM_BANKS-1:0]                map_wr_en;
    logic                                accept;
    logic                                last_beat;

    assign lanes = {FFT_OUT_11, FFT_OUT_10, FFT_OUT_9, FFT_OUT_8, FFT_OUT_7, FFT_OUT_6,
                    FFT_OUT_5,  FFT_OUT_4,  FFT_OUT_3, FFT_OUT_2, FFT_OUT_1, FFT_OUT_0};

    fft_out_map #(.DATA_WIDTH(DATA_WIDTH)) u_map (
        .point        (cfg_point),
        .point_2_mode (cfg_mode),
        .lanes        (lanes),
        .banks        (map_banks),
        .wr_en        (map_wr_en)
    );

    // The output register may refill in the same cycle the banks drain it.
    assign in_ready  = (state_q == S_RUN) && (!out_vld || mem_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == cfg_last);
    assign busy      = (state_q != S_IDLE);
    assign mem_wr_en = out_vld ? wr_en_q : '0;

    assign {mem_IN_7, mem_IN_6, mem_IN_5, mem_IN_4,
            mem_IN_3, mem_IN_2, mem_IN_1, mem_IN_0} = data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (accept && last_beat) state_d = S_DRAIN;
            S_DRAIN: if (!out_vld || mem_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cfg_point  <= '0;
            cfg_mode   <= 1'b0;
            cfg_last   <= '0;
            beat_cnt   <= '0;
            addr_ptr   <= '0;
            out_vld    <= 1'b0;
            wr_en_q    <= '0;
            data_q     <= '0;
            mem_addr   <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= (state_q == S_DRAIN) && (state_d == S_IDLE);

            if (start) begin
                if (state_q == S_IDLE) begin
                    cfg_point <= point;
                    cfg_mode  <= point_2_mode;
                    cfg_last  <= (frame_len == '0) ? '0 : frame_len - LEN_WIDTH'(1);
                    beat_cnt  <= '0;
                    addr_ptr  <= base_addr;
                    cfg_err   <= !point_legal(point);
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            if (accept) begin
                data_q   <= map_banks;
                wr_en_q  <= map_wr_en;
                mem_addr <= addr_ptr;
                addr_ptr <= addr_ptr + ADDR_WIDTH'(1);
                beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                out_vld  <= 1'b1;
            end else if (mem_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_demux.sv
// Directed self-checking bench for fft_out_demux: radix maps, backpressure,
// address wrap, illegal config and asynchronous reset mid-frame.
module tb_fft_out_demux;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    point;
    logic          point_2_mode;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] frame_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] lane [12];
    logic          mem_ready;
    logic [7:0]    mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in [8];
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fft_out_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .point        (point),
        .point_2_mode (point_2_mode),
        .base_addr    (base_addr),
        .frame_len    (frame_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .FFT_OUT_0    (lane[0]),
        .FFT_OUT_1    (lane[1]),
        .FFT_OUT_2    (lane[2]),
        .FFT_OUT_3    (lane[3]),
        .FFT_OUT_4    (lane[4]),
        .FFT_OUT_5    (lane[5]),
        .FFT_OUT_6    (lane[6]),
        .FFT_OUT_7    (lane[7]),
        .FFT_OUT_8    (lane[8]),
        .FFT_OUT_9    (lane[9]),
        .FFT_OUT_10   (lane[10]),
        .FFT_OUT_11   (lane[11]),
        .mem_ready    (mem_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_IN_0     (mem_in[0]),
        .mem_IN_1     (mem_in[1]),
        .mem_IN_2     (mem_in[2]),
        .mem_IN_3     (mem_in[3]),
        .mem_IN_4     (mem_in[4]),
        .mem_IN_5     (mem_in[5]),
        .mem_IN_6     (mem_in[6]),
        .mem_IN_7     (mem_in[7]),
        .busy         (busy),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int base);
        for (int k = 0; k < 12; k++) lane[k] = DW'(base + k);
    endtask

    task automatic do_start(input logic [2:0] p, input logic m, input int base, input int len);
        point        = p;
        point_2_mode = m;
        base_addr    = AW'(base);
        frame_len    = LW'(len);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; point = 3'd7; point_2_mode = 1'b0;
        base_addr = '0; frame_len = '0; in_valid = 1'b0; mem_ready = 1'b1;
        set_lanes(0);
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_in0", mem_in[0], 0);
        check("rst_in7", mem_in[7], 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", cfg_err, 0);
        rst_n = 1'b1;
        tick();

        // 1: radix 7, base 5, three beats at full throughput
        do_start(3'd7, 1'b0, 5, 3);
        check("p7_busy", busy, 1);
        check("p7_ready", in_ready, 1);
        in_valid = 1'b1;
        set_lanes(0);
        tick();
        check("p7_b0_addr", mem_addr, 5);
        check("p7_b0_wren", mem_wr_en, 8'h7F);
        check("p7_b0_bk0", mem_in[0], 0);
        check("p7_b0_bk1", mem_in[1], 1);
        check("p7_b0_bk2", mem_in[2], 5);
        check("p7_b0_bk3", mem_in[3], 4);
        check("p7_b0_bk4", mem_in[4], 3);
        check("p7_b0_bk5", mem_in[5], 6);
        check("p7_b0_bk6", mem_in[6], 2);
        set_lanes(16);
        tick();
        check("p7_b1_addr", mem_addr, 6);
        check("p7_b1_bk6", mem_in[6], 16'h12);
        check("p7_b1_bk2", mem_in[2], 16'h15);
        set_lanes(32);
        tick();
        check("p7_b2_addr", mem_addr, 7);
        check("p7_b2_bk6", mem_in[6], 16'h22);
        check("p7_b2_bk2", mem_in[2], 16'h25);
        check("p7_b2_wren", mem_wr_en, 8'h7F);
        check("p7_drain_ready", in_ready, 0);
        check("p7_b2_done", frame_done, 0);
        in_valid = 1'b0;
        tick();
        check("p7_done", frame_done, 1);
        check("p7_wren_idle", mem_wr_en, 0);
        check("p7_busy_idle", busy, 0);
        check("p7_hold_bk6", mem_in[6], 16'h22);
        tick();
        check("p7_done_pulse", frame_done, 0);

        // 2: radix 2 with 6 banks, then with 8 banks
        do_start(3'd2, 1'b0, 0, 1);
        set_lanes(16'h40);
        in_valid = 1'b1;
        tick();
        check("p2m0_wren", mem_wr_en, 8'h3F);
        check("p2m0_bk0", mem_in[0], 16'h41);
        check("p2m0_bk5", mem_in[5], 16'h49);
        in_valid = 1'b0;
        tick();
        check("p2m0_done", frame_done, 1);
        do_start(3'd2, 1'b1, 10, 1);
        set_lanes(16'h80);
        in_valid = 1'b1;
        tick();
        check("p2m1_wren", mem_wr_en, 8'hFF);
        check("p2m1_addr", mem_addr, 10);
        check("p2m1_bk6", mem_in[6], 16'h8A);
        check("p2m1_bk7", mem_in[7], 16'h8B);
        in_valid = 1'b0;
        tick();
        check("p2m1_done", frame_done, 1);

        // 3: radix 4 with bank backpressure after the first beat
        do_start(3'd4, 1'b0, 20, 4);
        set_lanes(16'h100);
        in_valid = 1'b1;
        tick();
        check("p4_b0_addr", mem_addr, 20);
        check("p4_b0_wren", mem_wr_en, 8'h0F);
        check("p4_b0_bk0", mem_in[0], 16'h101);
        check("p4_b0_bk1", mem_in[1], 16'h105);
        check("p4_b0_bk2", mem_in[2], 16'h102);
        check("p4_b0_bk3", mem_in[3], 16'h106);
        mem_ready = 1'b0;
        set_lanes(16'h110);
        #1;
        check("p4_stall_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p4_stall_addr", mem_addr, 20);
            check("p4_stall_bk0", mem_in[0], 16'h101);
            check("p4_stall_wren", mem_wr_en, 8'h0F);
            check("p4_stall_rdy", in_ready, 0);
        end
        mem_ready = 1'b1;
        #1;
        check("p4_resume_ready", in_ready, 1);
        tick();
        check("p4_b1_addr", mem_addr, 21);
        check("p4_b1_bk0", mem_in[0], 16'h111);
        set_lanes(16'h120);
        tick();
        check("p4_b2_addr", mem_addr, 22);
        check("p4_b2_bk0", mem_in[0], 16'h121);
        set_lanes(16'h130);
        tick();
        check("p4_b3_addr", mem_addr, 23);
        check("p4_b3_bk3", mem_in[3], 16'h136);
        in_valid = 1'b0;
        tick();
        check("p4_done", frame_done, 1);

        // 4: radix 5 with address wrap from 62
        do_start(3'd5, 1'b0, 62, 4);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_lanes(16 * i);
            tick();
            check("p5_wrap_addr", mem_addr, (62 + i) % 64);
            check("p5_wrap_wren", mem_wr_en, 8'h1F);
            check("p5_wrap_bk4", mem_in[4], 16 * i + 2);
            check("p5_wrap_bk2", mem_in[2], 16 * i + 4);
        end
        in_valid = 1'b0;
        tick();
        check("p5_wrap_done", frame_done, 1);

        // 5: illegal radix, clear by a legal start, then start while busy
        do_start(3'd6, 1'b0, 0, 2);
        check("ill_err", cfg_err, 1);
        in_valid = 1'b1;
        tick();
        check("ill_b0_wren", mem_wr_en, 0);
        tick();
        check("ill_b1_wren", mem_wr_en, 0);
        in_valid = 1'b0;
        tick();
        check("ill_done", frame_done, 1);
        check("ill_err_sticky", cfg_err, 1);
        do_start(3'd3, 1'b0, 0, 1);
        check("clr_err", cfg_err, 0);
        do_start(3'd7, 1'b0, 40, 3);
        check("busy_start_err", cfg_err, 1);
        check("busy_start_busy", busy, 1);
        set_lanes(16'h200);
        in_valid = 1'b1;
        tick();
        check("p3_wren", mem_wr_en, 8'h3F);
        check("p3_addr", mem_addr, 0);
        check("p3_bk3", mem_in[3], 16'h207);
        check("p3_bk4", mem_in[4], 16'h205);
        in_valid = 1'b0;
        tick();
        check("p3_done", frame_done, 1);

        // 6: asynchronous reset during beat 2 of a radix-5 frame
        do_start(3'd5, 1'b0, 30, 4);
        check("p5r_err_clr", cfg_err, 0);
        set_lanes(16'h300);
        in_valid = 1'b1;
        tick();
        set_lanes(16'h310);
        tick();
        check("p5r_b1_addr", mem_addr, 31);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wren", mem_wr_en, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_bk0", mem_in[0], 0);
        check("arst_busy", busy, 0);
        check("arst_ready", in_ready, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("arst_no_done", frame_done, 0);
        check("arst_idle", busy, 0);
        do_start(3'd5, 1'b0, 30, 2);
        set_lanes(16'h400);
        in_valid = 1'b1;
        tick();
        check("p5n_addr0", mem_addr, 30);
        check("p5n_wren", mem_wr_en, 8'h1F);
        check("p5n_bk3", mem_in[3], 16'h403);
        tick();
        check("p5n_addr1", mem_addr, 31);
        in_valid = 1'b0;
        tick();
        check("p5n_done", frame_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
